// File: rtl/fixed_point_multiplier_if.sv
// Handshake/data bundle for the fixed-point multiplier: operands with a valid
// flag in, scaled product with a valid flag out.
interface fixed_point_multiplier_if #(
  parameter int DATA_WIDTH = 10
);
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] coef;
  logic signed [DATA_WIDTH-1:0] data;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] product;

  modport master (
    output in_valid, coef, data,
    input  out_valid, product
  );

  modport slave (
    input  in_valid, coef, data,
    output out_valid, product
  );
endinterface

// File: rtl/fixed_point_multiplier.sv
// Two-stage signed fixed-point multiplier: full-precision product, then
// rescale by FRAC_BITS with optional round-half-up and optional saturation.
module fixed_point_multiplier #(
  parameter int DATA_WIDTH = 10,
  parameter int FRAC_BITS  = 8,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fixed_point_multiplier_if.slave bus
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int RW = PW + 1;

  // Rounding constant lives in RW bits so P + 2^(FRAC_BITS-1) never overflows.
  localparam logic signed [RW-1:0] RND_C =
      (ROUND != 0 && FRAC_BITS > 0) ? (RW'(1) << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0))
                                    : '0;
  localparam logic signed [RW-1:0] SAT_MAX =
      {{(DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN =
      {{(DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic signed [PW-1:0]         coef_ext;
  logic signed [PW-1:0]         data_ext;
  logic signed [PW-1:0]         prod_d;
  logic signed [PW-1:0]         prod_q;
  logic                         v1_q;
  logic signed [RW-1:0]         sum_d;
  logic signed [RW-1:0]         shifted_d;
  logic                         over_d;
  logic                         under_d;
  logic signed [DATA_WIDTH-1:0] product_d;
  logic signed [DATA_WIDTH-1:0] product_q;
  logic                         out_valid_q;

  assign coef_ext = {{DATA_WIDTH{bus.coef[DATA_WIDTH-1]}}, bus.coef};
  assign data_ext = {{DATA_WIDTH{bus.data[DATA_WIDTH-1]}}, bus.data};
  assign prod_d   = coef_ext * data_ext;

  assign sum_d     = {prod_q[PW-1], prod_q} + RND_C;
  assign shifted_d = sum_d >>> FRAC_BITS;
  assign over_d    = (shifted_d > SAT_MAX);
  assign under_d   = (shifted_d < SAT_MIN);

  always_comb begin
    product_d = shifted_d[DATA_WIDTH-1:0];
    if (SATURATE != 0) begin
      if (over_d) begin
        product_d = SAT_MAX[DATA_WIDTH-1:0];
      end else if (under_d) begin
        product_d = SAT_MIN[DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q      <= '0;
      v1_q        <= 1'b0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      v1_q        <= bus.in_valid;
      product_q   <= product_d;
      out_valid_q <= v1_q;
    end
  end

  assign bus.product   = product_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Runs all four ROUND/SATURATE variants side by side on shared stimulus and
// checks each against an arithmetic reference of the scaling rules.
module tb_fixed_point_multiplier;
  localparam int DW = 10;
  localparam int FB = 8;
  localparam int NCFG = 4;

  typedef struct {
    bit v;
    int val;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic signed [DW-1:0] coef;
  logic signed [DW-1:0] data;
  logic [NCFG-1:0]          out_valid_w;
  logic [NCFG-1:0][DW-1:0]  product_w;

  int checks = 0;
  int errors = 0;
  exp_t expq [NCFG][$];

  // Variant k uses ROUND = k % 2, SATURATE = k / 2.
  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    fixed_point_multiplier_if #(.DATA_WIDTH(DW)) bus ();
    assign bus.in_valid = in_valid;
    assign bus.coef     = coef;
    assign bus.data     = data;
    assign out_valid_w[gi] = bus.out_valid;
    assign product_w[gi]   = bus.product;

    fixed_point_multiplier #(
      .DATA_WIDTH(DW),
      .FRAC_BITS (FB),
      .ROUND     (gi % 2),
      .SATURATE  (gi / 2)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact product, floor division by 2^FB, then clamp or wrap.
  function automatic int ref_mul(input int c, input int d, input int rnd, input int sat);
    longint p;
    longint q;
    longint scale;
    scale = longint'(1) << FB;
    p = longint'(c) * longint'(d);
    if (rnd != 0 && FB > 0) p = p + scale / 2;
    q = p / scale;
    if (p < 0 && (p % scale) != 0) q = q - 1;
    if (sat != 0) begin
      if (q > 511) q = 511;
      if (q < -512) q = -512;
    end else begin
      q = q % 1024;
      if (q < 0) q = q + 1024;
      if (q >= 512) q = q - 1024;
    end
    return int'(q);
  endfunction

  function automatic int rand_op();
    int r;
    r = int'($urandom_range(0, 1023));
    return (r >= 512) ? r - 1024 : r;
  endfunction

  task automatic reset_model();
    exp_t item;
    item.v = 1'b0;
    item.val = 0;
    for (int k = 0; k < NCFG; k++) begin
      expq[k].delete();
      expq[k].push_back(item);
    end
  endtask

  // Called at a falling edge: apply one input, step one clock, check the
  // output due from the previous input.
  task automatic drive_cycle(input bit v, input int c, input int d, input int e [NCFG],
                             input string tag);
    exp_t item;
    in_valid = v;
    coef = DW'(c);
    data = DW'(d);
    for (int k = 0; k < NCFG; k++) begin
      item.v = v;
      item.val = e[k];
      expq[k].push_back(item);
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NCFG; k++) begin
      item = expq[k].pop_front();
      checks++;
      if (out_valid_w[k] !== item.v) begin
        errors++;
        $display("FAIL %s valid cfg%0d: got %0b, expected %0b", tag, k, out_valid_w[k], item.v);
      end
      if (item.v) begin
        checks++;
        if (product_w[k] !== DW'(item.val)) begin
          errors++;
          $display("FAIL %s product cfg%0d: got %0d, expected %0d", tag, k,
                   $signed(product_w[k]), item.val);
        end
      end
    end
    $display("%s: in v=%0b coef=%0d data=%0d | out v=%b p=%0d/%0d/%0d/%0d", tag, v, c, d,
             out_valid_w, $signed(product_w[0]), $signed(product_w[1]),
             $signed(product_w[2]), $signed(product_w[3]));
  endtask

  task automatic model_cycle(input bit v, input int c, input int d, input string tag);
    int e [NCFG];
    for (int k = 0; k < NCFG; k++) e[k] = ref_mul(c, d, k % 2, k / 2);
    drive_cycle(v, c, d, e, tag);
  endtask

  task automatic check_cleared(input string tag);
    for (int k = 0; k < NCFG; k++) begin
      checks++;
      if (out_valid_w[k] !== 1'b0 || product_w[k] !== '0) begin
        errors++;
        $display("FAIL %s cfg%0d: got valid=%0b product=%0d, expected valid=0 product=0",
                 tag, k, out_valid_w[k], $signed(product_w[k]));
      end
    end
    $display("%s: out v=%b while rst_n=%0b", tag, out_valid_w, rst_n);
  endtask

  task automatic test_reset();
    int e [NCFG];
    rst_n = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      coef = DW'(rand_op());
      data = DW'(rand_op());
      #1;
      check_cleared("reset_hold");
      @(negedge clk);
    end
    rst_n = 1'b1;
    reset_model();
    e = '{75, 76, 75, 76};
    drive_cycle(1'b1, 76, 255, e, "reset_first");
    model_cycle(1'b0, 0, 0, "reset_drain");
  endtask

  task automatic test_rounding();
    int e [NCFG];
    e = '{75, 76, 75, 76};
    drive_cycle(1'b1, 76, 255, e, "round_pos");
    e = '{-84, -84, -84, -84};
    drive_cycle(1'b1, -107, 200, e, "round_neg");
    model_cycle(1'b0, 0, 0, "round_drain");
  endtask

  task automatic test_overflow();
    int e [NCFG];
    e = '{-4, -4, 511, 511};
    drive_cycle(1'b1, 511, 511, e, "ovf_pos");
    e = '{2, 2, -512, -512};
    drive_cycle(1'b1, -512, 511, e, "ovf_neg");
    model_cycle(1'b0, 0, 0, "ovf_drain");
  endtask

  task automatic test_extremes();
    int e [NCFG];
    e = '{0, 0, 511, 511};
    drive_cycle(1'b1, -512, -512, e, "ext_minmin");
    e = '{0, 0, 0, 0};
    drive_cycle(1'b1, 0, rand_op(), e, "ext_zero_coef");
    drive_cycle(1'b1, 0, -512, e, "ext_zero_min");
    drive_cycle(1'b1, rand_op(), 0, e, "ext_zero_data");
    model_cycle(1'b0, 0, 0, "ext_drain");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) begin
      model_cycle(i != 4, rand_op(), rand_op(), "b2b");
    end
    model_cycle(1'b0, 0, 0, "b2b_drain");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      model_cycle($urandom_range(0, 7) != 0, rand_op(), rand_op(), "rand");
    end
    model_cycle(1'b0, 0, 0, "rand_drain");
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) model_cycle(1'b1, rand_op(), rand_op(), "mid_fill");
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_cleared("mid_async");
    @(negedge clk);
    check_cleared("mid_hold");
    rst_n = 1'b1;
    reset_model();
    for (int i = 0; i < 6; i++) model_cycle(1'b1, rand_op(), rand_op(), "mid_after");
    model_cycle(1'b0, 0, 0, "mid_drain");
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    coef = '0;
    data = '0;
    for (int k = 0; k < NCFG; k++) expq[k].delete();
    @(negedge clk);
    test_reset();
    test_rounding();
    test_overflow();
    test_extremes();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
